// File: rtl/cci_mpf_quiesce_ctrl_if.sv
// rtl/cci_mpf_quiesce_ctrl_if.sv - quiesce request / MPF occupancy / drain status bundle
interface cci_mpf_quiesce_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 quiesce_req;
  logic                 err_clr;
  logic                 c0NotEmpty;
  logic                 c1NotEmpty;
  logic                 tx_enable;
  logic                 quiesce_done;
  logic                 timeout_err;
  logic [CNT_WIDTH-1:0] drain_cycles;

  modport master (
    output quiesce_req, err_clr, c0NotEmpty, c1NotEmpty,
    input  tx_enable, quiesce_done, timeout_err, drain_cycles
  );

  modport slave (
    input  quiesce_req, err_clr, c0NotEmpty, c1NotEmpty,
    output tx_enable, quiesce_done, timeout_err, drain_cycles
  );
endinterface

// File: rtl/cci_mpf_quiesce_ctrl.sv
// rtl/cci_mpf_quiesce_ctrl.sv - MPF drain controller: gates test_afu requests, waits for MPF idle, reports drain time
// Optional drain timeout is enabled by defining MPF_QUIESCE_TIMEOUT_EN.
module cci_mpf_quiesce_ctrl #(
  parameter int QUIET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1 << 20,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cci_mpf_quiesce_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] QUIET_LAST = CNT_WIDTH'(QUIET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] drain_q;
  logic [CNT_WIDTH-1:0] drain_d;
  logic [CNT_WIDTH-1:0] quiet_q;
  logic [CNT_WIDTH-1:0] quiet_d;
  logic                 tx_enable_q;
  logic                 done_q;
  logic                 busy;
  logic                 quiet_hit;
  logic                 timeout_hit;

  assign busy      = bus.c0NotEmpty | bus.c1NotEmpty;
  assign quiet_hit = !busy && (quiet_q == QUIET_LAST);

`ifdef MPF_QUIESCE_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic err_q;
  logic err_d;

  // Fires on the cycle whose increment makes drain_cycles equal TIMEOUT_CYCLES.
  assign timeout_hit     = (drain_q == TIMEOUT_LAST);
  assign bus.timeout_err = err_q;
`else
  logic unused_cfg;

  assign timeout_hit     = 1'b0;
  assign unused_cfg      = &{1'b0, bus.err_clr, (TIMEOUT_CYCLES != 0)};
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.tx_enable    = tx_enable_q;
  assign bus.quiesce_done = done_q;
  assign bus.drain_cycles = drain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort (request dropped) beats both completion and timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.quiesce_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.quiesce_req)            state_d = ST_RUN;
        else if (quiet_hit || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.quiesce_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    drain_d = drain_q;
    quiet_d = quiet_q;
`ifdef MPF_QUIESCE_TIMEOUT_EN
    err_d   = err_q;
    if (bus.err_clr) err_d = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (bus.quiesce_req) begin
          drain_d = '0;
          quiet_d = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.quiesce_req) begin
          if (drain_q != CNT_MAX) drain_d = drain_q + 1'b1;
          quiet_d = busy ? '0 : quiet_q + 1'b1;
`ifdef MPF_QUIESCE_TIMEOUT_EN
          // A quiet completion in the same cycle is a clean drain, not a timeout.
          if (timeout_hit && !quiet_hit) err_d = 1'b1;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_q     <= '0;
      quiet_q     <= '0;
      tx_enable_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef MPF_QUIESCE_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      drain_q     <= drain_d;
      quiet_q     <= quiet_d;
      tx_enable_q <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
`ifdef MPF_QUIESCE_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cci_mpf_quiesce_ctrl.sv
// tb/tb_cci_mpf_quiesce_ctrl.sv - directed and random checks of cci_mpf_quiesce_ctrl against a cycle-stamp model
module tb_cci_mpf_quiesce_ctrl;
  localparam int QUIET   = 16;
  localparam int TIMEOUT = 100;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef MPF_QUIESCE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cci_mpf_quiesce_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  cci_mpf_quiesce_ctrl #(
    .QUIET_CYCLES  (QUIET),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a drain is "active" from the request until done/abort; it completes once
  // the run of consecutive idle cycles (measured by cycle stamps) reaches QUIET.
  int m_cycle = 0;
  int m_drain;
  int m_quiet_from;
  bit m_active;
  bit m_done;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_drain = 0; m_quiet_from = 0; m_active = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit req, input bit busy, input bit clr);
    if (TO_EN && clr) m_err = 0;
    if (m_done) begin
      if (!req) m_done = 0;
    end else if (m_active) begin
      if (!req) begin
        m_active = 0;
      end else begin
        m_drain = (m_drain < CNT_MAX) ? m_drain + 1 : CNT_MAX;
        if (busy) m_quiet_from = m_cycle + 1;
        if (!busy && (m_cycle - m_quiet_from + 1) >= QUIET) begin
          m_active = 0; m_done = 1;
        end else if (TO_EN && m_drain == TIMEOUT) begin
          m_active = 0; m_done = 1; m_err = 1;
        end
      end
    end else if (req) begin
      m_active = 1; m_drain = 0; m_quiet_from = m_cycle + 1;
    end
    m_cycle++;
  endfunction

  task automatic check_model();
    chk("m_tx_enable",    32'(bus.tx_enable),    32'(!(m_active || m_done)));
    chk("m_quiesce_done", 32'(bus.quiesce_done), 32'(m_done));
    chk("m_drain_cycles", 32'(bus.drain_cycles), 32'(m_drain));
    chk("m_timeout_err",  32'(bus.timeout_err),  32'(m_err));
  endtask

  task automatic tick(input bit req, input bit c0, input bit c1, input bit clr);
    bus.quiesce_req = req;
    bus.c0NotEmpty  = c0;
    bus.c1NotEmpty  = c1;
    bus.err_clr     = clr;
    @(posedge clk);
    model_step(req, c0 | c1, clr);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx"},    32'(bus.tx_enable),    32'd1);
    chk({tag, "_done"},  32'(bus.quiesce_done), 32'd0);
    chk({tag, "_err"},   32'(bus.timeout_err),  32'd0);
    chk({tag, "_drain"}, 32'(bus.drain_cycles), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.quiesce_req = 0; bus.c0NotEmpty = 0; bus.c1NotEmpty = 0; bus.err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Runs idle DRAIN cycles until quiesce_done rises; returns the cycle it was first seen.
  task automatic wait_done(input int cyc_in, input int limit, output int done_at);
    int cyc = cyc_in;
    done_at = -1;
    while (cyc < limit && done_at < 0) begin
      tick(1, 0, 0, 0);
      cyc++;
      if (bus.quiesce_done) done_at = cyc;
    end
  endtask

  initial begin
    int  done_at;
    bit  saw_done;
    bit  req_r;
    bit  c0_r, c1_r, clr_r;

    do_reset();

    // Idle MPF: tx_enable drops at cycle 1, done at cycle 17 with 16 drain cycles.
    tick(1, 0, 0, 0);
    chk("t1_tx_cycle1", 32'(bus.tx_enable), 32'd0);
    wait_done(1, 60, done_at);
    chk("t1_done_cycle", 32'(done_at), 32'd17);
    chk("t1_drain", 32'(bus.drain_cycles), 32'd16);

    // Drop request in DONE, then re-request clears drain_cycles.
    tick(0, 0, 0, 0);
    chk("t5_done_low", 32'(bus.quiesce_done), 32'd0);
    chk("t5_tx_high",  32'(bus.tx_enable),    32'd1);
    chk("t5_drain_kept", 32'(bus.drain_cycles), 32'd16);
    tick(1, 0, 0, 0);
    chk("t5_drain_clr", 32'(bus.drain_cycles), 32'd0);

    // c1 busy for 40 DRAIN cycles: done 16 cycles after it falls, 56 drain cycles.
    for (int i = 1; i <= 40; i++) tick(1, 0, 1, 0);
    chk("t2_not_done", 32'(bus.quiesce_done), 32'd0);
    wait_done(41, 120, done_at);
    chk("t2_done_cycle", 32'(done_at), 32'd57);
    chk("t2_drain", 32'(bus.drain_cycles), 32'd56);
    tick(0, 0, 0, 0);

    // One-cycle c0 glitch when the idle run has reached 10.
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    wait_done(12, 80, done_at);
    chk("t3_done_cycle", 32'(done_at), 32'd28);
    chk("t3_drain", 32'(bus.drain_cycles), 32'd27);
    tick(0, 0, 0, 0);

    // Abort mid-DRAIN: tx_enable back next cycle, drain count kept, no done.
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("t4_tx_high", 32'(bus.tx_enable), 32'd1);
    chk("t4_drain_kept", 32'(bus.drain_cycles), 32'd5);
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      saw_done |= bus.quiesce_done;
    end
    chk("t4_never_done", 32'(saw_done), 32'd0);

    // c0 stuck high.
    tick(1, 1, 0, 0);
    saw_done = 0;
    for (int i = 0; i < 300 && !saw_done; i++) begin
      tick(1, 1, 0, 0);
      saw_done |= bus.quiesce_done;
    end
`ifdef MPF_QUIESCE_TIMEOUT_EN
    chk("t6_done", 32'(saw_done), 32'd1);
    chk("t6_err_set", 32'(bus.timeout_err), 32'd1);
    chk("t6_drain", 32'(bus.drain_cycles), 32'd100);
    tick(1, 1, 0, 1);
    chk("t6_err_clr", 32'(bus.timeout_err), 32'd0);
    chk("t6_done_held", 32'(bus.quiesce_done), 32'd1);
`else
    chk("t6_never_done", 32'(saw_done), 32'd0);
    chk("t6_err_zero", 32'(bus.timeout_err), 32'd0);
    chk("t6_drain_sat", 32'(bus.drain_cycles), 32'(CNT_MAX));
    tick(1, 1, 0, 1);
    chk("t6_clr_ignored", 32'(bus.timeout_err), 32'd0);
`endif
    tick(0, 0, 0, 0);

    // Asynchronous reset in DRAIN, asserted between clock edges.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("t6_async_rst");
    model_reset();
    bus.quiesce_req = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic against the model.
    req_r = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) req_r = ~req_r;
      c0_r  = ($urandom_range(0, 23) == 0);
      c1_r  = ($urandom_range(0, 31) == 0);
      clr_r = ($urandom_range(0, 49) == 0);
      tick(req_r, c0_r, c1_r, clr_r);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
